// File: rtl/memshare_l1pa_spr_regfile_if.sv
// Request/feedback bundle between the L1PA address mapping unit (master)
// and the L1PA_SPR page register file (slave).
interface memshare_l1pa_spr_regfile_if #(
  parameter int ADDR_WIDTH  = 5,
  parameter int SHIFT_WIDTH = 3
);
  logic                   rd_en_i;
  logic [ADDR_WIDTH-1:0]  regFile_raddr_i;
  logic                   wr_en_i;
  logic [ADDR_WIDTH-1:0]  waddr_i;
  logic [SHIFT_WIDTH-1:0] wdata_shift_i;
  logic [SHIFT_WIDTH-1:0] wdata_shiftDelta_i;
  logic                   wdata_isGtr_i;
  logic [SHIFT_WIDTH-1:0] l1pa_shift_o;
  logic [SHIFT_WIDTH-1:0] shiftDelta_o;
  logic                   isGtr_o;
  logic                   rdata_valid_o;
  logic                   init_done_o;
  logic                   raddr_err_o;
  logic                   wr_err_o;

  modport master (
    output rd_en_i, regFile_raddr_i, wr_en_i, waddr_i,
           wdata_shift_i, wdata_shiftDelta_i, wdata_isGtr_i,
    input  l1pa_shift_o, shiftDelta_o, isGtr_o, rdata_valid_o,
           init_done_o, raddr_err_o, wr_err_o
  );

  modport slave (
    input  rd_en_i, regFile_raddr_i, wr_en_i, waddr_i,
           wdata_shift_i, wdata_shiftDelta_i, wdata_isGtr_i,
    output l1pa_shift_o, shiftDelta_o, isGtr_o, rdata_valid_o,
           init_done_o, raddr_err_o, wr_err_o
  );
endinterface

// File: rtl/memshare_l1pa_spr_regfile.sv
// L1PA_SPR page register file: one {shift, shiftDelta, isGtr} word per page.
// After reset the pages are swept to zero one per cycle (INIT), then reads
// and writes are served with a 1-cycle registered read and write-through bypass.
module memshare_l1pa_spr_regfile #(
  parameter int RQST_BITWIDTH       = 5,
  parameter int REGFILE_PAGE_NUM    = 43,
  parameter int REGFILE_ADDR_WIDTH  = RQST_BITWIDTH,
  parameter int L1PA_SHIFT_BITWIDTH = $clog2(RQST_BITWIDTH)
) (
  input logic                          sys_clk,
  input logic                          rst,
  memshare_l1pa_spr_regfile_if.slave   bus
);

  localparam int SW    = L1PA_SHIFT_BITWIDTH;
  localparam int IDX_W = (REGFILE_PAGE_NUM > 1) ? $clog2(REGFILE_PAGE_NUM) : 1;

  typedef enum logic {INIT, READY} state_t;

  typedef struct packed {
    logic [SW-1:0] shift;
    logic [SW-1:0] delta;
    logic          gtr;
  } page_t;

  page_t             pages [REGFILE_PAGE_NUM];
  state_t            state;
  logic [IDX_W-1:0]  clr_cnt;

  page_t             wdata;
  page_t             rword;
  logic [IDX_W-1:0]  ridx;
  logic [IDX_W-1:0]  widx;
  logic              raddr_ok;
  logic              waddr_ok;
  logic              bypass;

  // Decode addresses, range checks and the write-through read word.
  always_comb begin
    wdata    = '{shift: bus.wdata_shift_i, delta: bus.wdata_shiftDelta_i,
                 gtr: bus.wdata_isGtr_i};
    ridx     = IDX_W'(bus.regFile_raddr_i);
    widx     = IDX_W'(bus.waddr_i);
    raddr_ok = 32'(bus.regFile_raddr_i) < $unsigned(REGFILE_PAGE_NUM);
    waddr_ok = 32'(bus.waddr_i) < $unsigned(REGFILE_PAGE_NUM);
    bypass   = bus.wr_en_i && waddr_ok && (bus.waddr_i == bus.regFile_raddr_i);
    rword    = bypass ? wdata : pages[ridx];
  end

  // Page storage: zeroing sweep during INIT, accepted writes during READY.
  // NOTE: the array has no reset branch on purpose; the INIT sweep clears it
  // and keeps it mappable to plain RAM/flops without a reset network.
  always_ff @(posedge sys_clk) begin
    if (state == INIT) begin
      pages[clr_cnt] <= '0;
    end else if (!rst && bus.wr_en_i && waddr_ok) begin
      pages[widx] <= wdata;
    end
  end

  // Control FSM with registered read data, valid and error strobes.
  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state              <= INIT;
      clr_cnt            <= '0;
      bus.l1pa_shift_o   <= '0;
      bus.shiftDelta_o   <= '0;
      bus.isGtr_o        <= 1'b0;
      bus.rdata_valid_o  <= 1'b0;
      bus.init_done_o    <= 1'b0;
      bus.raddr_err_o    <= 1'b0;
      bus.wr_err_o       <= 1'b0;
    end else begin
      bus.rdata_valid_o <= bus.rd_en_i;
      bus.raddr_err_o   <= 1'b0;
      bus.wr_err_o      <= 1'b0;
      unique case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(REGFILE_PAGE_NUM - 1)) begin
            state           <= READY;
            bus.init_done_o <= 1'b1;
          end
          if (bus.rd_en_i) begin
            bus.l1pa_shift_o <= '0;
            bus.shiftDelta_o <= '0;
            bus.isGtr_o      <= 1'b0;
          end
          bus.wr_err_o <= bus.wr_en_i;
        end
        READY: begin
          if (bus.rd_en_i) begin
            if (raddr_ok) begin
              bus.l1pa_shift_o <= rword.shift;
              bus.shiftDelta_o <= rword.delta;
              bus.isGtr_o      <= rword.gtr;
            end else begin
              bus.l1pa_shift_o <= '0;
              bus.shiftDelta_o <= '0;
              bus.isGtr_o      <= 1'b0;
              bus.raddr_err_o  <= 1'b1;
            end
          end
          bus.wr_err_o <= bus.wr_en_i && !waddr_ok;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_memshare_l1pa_spr_regfile.sv
// Directed bench for the L1PA_SPR register file. Each cycle pushes the
// expected outputs from a behavioural model into a scoreboard queue and
// pops/compares them at the following falling edge.
module tb_memshare_l1pa_spr_regfile;

  localparam int AW    = 6;
  localparam int SW    = 3;
  localparam int PAGES = 43;

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] shift;
    logic [SW-1:0] delta;
    logic          gtr;
    logic          rerr;
    logic          werr;
    logic          done;
  } obs_t;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  memshare_l1pa_spr_regfile_if #(.ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)) bus ();

  memshare_l1pa_spr_regfile #(
    .RQST_BITWIDTH      (5),
    .REGFILE_PAGE_NUM   (PAGES),
    .REGFILE_ADDR_WIDTH (AW),
    .L1PA_SHIFT_BITWIDTH(SW)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  obs_t          exp_q [$];
  logic [6:0]    model_mem [PAGES];
  logic [6:0]    held;
  bit            m_ready;
  int            m_cnt;
  int            tests;
  int            fails;

  function automatic obs_t observe();
    obs_t o;
    o.valid = bus.rdata_valid_o;
    o.shift = bus.l1pa_shift_o;
    o.delta = bus.shiftDelta_o;
    o.gtr   = bus.isGtr_o;
    o.rerr  = bus.raddr_err_o;
    o.werr  = bus.wr_err_o;
    o.done  = bus.init_done_o;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; the model predicts the outputs seen after the edge.
  task automatic tick(input string tag, input logic rd, input int ra, input logic wr,
                      input int wa, input logic [2:0] sh, input logic [2:0] dl, input logic g);
    obs_t       e;
    logic [6:0] wd;
    bit         wok;
    bit         rok;
    bus.rd_en_i            = rd;
    bus.regFile_raddr_i    = AW'(ra);
    bus.wr_en_i            = wr;
    bus.waddr_i            = AW'(wa);
    bus.wdata_shift_i      = sh;
    bus.wdata_shiftDelta_i = dl;
    bus.wdata_isGtr_i      = g;
    wd  = {sh, dl, g};
    wok = (wa < PAGES);
    rok = (ra < PAGES);
    e   = '0;
    e.valid = rd;
    if (!m_ready) begin
      if (rd) held = '0;
      e.werr = wr;
    end else begin
      if (rd) begin
        if (rok) held = (wr && wok && wa == ra) ? wd : model_mem[ra];
        else begin
          held   = '0;
          e.rerr = 1'b1;
        end
      end
      e.werr = wr && !wok;
      if (wr && wok) model_mem[wa] = wd;
    end
    {e.shift, e.delta, e.gtr} = held;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == PAGES) m_ready = 1'b1;
    end
    e.done = m_ready;
    exp_q.push_back(e);
    @(negedge sys_clk);
    check(tag, 32'(observe()), 32'(exp_q.pop_front()));
  endtask

  task automatic idle(input string tag);
    tick(tag, 1'b0, 0, 1'b0, 0, 3'd0, 3'd0, 1'b0);
  endtask

  // Assert reset for one edge (optionally with a read pending) and check outputs clear.
  task automatic do_reset(input logic pend_rd);
    bus.rd_en_i         = pend_rd;
    bus.regFile_raddr_i = AW'(1);
    bus.wr_en_i         = 1'b0;
    rst                 = 1'b1;
    @(negedge sys_clk);
    check("reset_outputs", 32'(observe()), 32'(obs_t'('0)));
    m_ready = 1'b0;
    m_cnt   = 0;
    held    = '0;
    rst     = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask

  // Run the clear sequence and check its length; optional INIT-time stimulus in the first cycles.
  task automatic run_init(input bit poke);
    int n = 0;
    while (bus.init_done_o !== 1'b1 && n < 100) begin
      if (poke && n == 0)      tick("init_write", 1'b0, 0, 1'b1, 5, 3'd7, 3'd7, 1'b1);
      else if (poke && n == 1) tick("init_read",  1'b1, 3, 1'b0, 0, 3'd0, 3'd0, 1'b0);
      else                     idle("init_idle");
      n++;
    end
    check("init_cycles", 32'(n), 32'(PAGES));
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    m_ready = 1'b0;
    m_cnt   = 0;
    held    = '0;
    for (int i = 0; i < PAGES; i++) model_mem[i] = '0;
    bus.rd_en_i = 1'b0; bus.regFile_raddr_i = '0; bus.wr_en_i = 1'b0; bus.waddr_i = '0;
    bus.wdata_shift_i = '0; bus.wdata_shiftDelta_i = '0; bus.wdata_isGtr_i = 1'b0;

    @(negedge sys_clk);
    do_reset(1'b1);
    run_init(1'b1);

    for (int i = 0; i < PAGES; i++) tick("sweep_zero", 1'b1, i, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    idle("sweep_end");

    tick("wr_p7",     1'b0, 0, 1'b1, 7, 3'd3, 3'd2, 1'b1);
    tick("rd_p7",     1'b1, 7, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    idle("hold_p7");
    idle("hold_p7_2");

    tick("bypass_p12", 1'b1, 12, 1'b1, 12, 3'd1, 3'd4, 1'b0);
    idle("hold_p12");

    tick("wr_p1", 1'b0, 0, 1'b1, 1, 3'd5, 3'd1, 1'b1);
    tick("wr_p2", 1'b0, 0, 1'b1, 2, 3'd6, 3'd3, 1'b0);
    tick("wr_p3", 1'b0, 0, 1'b1, 3, 3'd2, 3'd7, 1'b1);
    tick("b2b_p1", 1'b1, 1, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    tick("b2b_p2", 1'b1, 2, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    tick("b2b_p3", 1'b1, 3, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    idle("b2b_end");

    tick("rd_oob50",  1'b1, 50, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    idle("rerr_clear");
    tick("wr_oob45",  1'b0, 0, 1'b1, 45, 3'd7, 3'd7, 1'b1);
    idle("werr_clear");
    tick("wr_p42",    1'b0, 0, 1'b1, 42, 3'd4, 3'd5, 1'b1);
    tick("rd_p42",    1'b1, 42, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    tick("rd_oob43",  1'b1, 43, 1'b1, 43, 3'd1, 3'd1, 1'b1);
    tick("bypass_miss", 1'b1, 7, 1'b1, 8, 3'd6, 3'd6, 1'b0);
    tick("rd_p8",     1'b1, 8, 1'b0, 0, 3'd0, 3'd0, 1'b0);

    for (int i = 0; i < PAGES; i++) tick("sweep_final", 1'b1, i, 1'b0, 0, 3'd0, 3'd0, 1'b0);

    do_reset(1'b0);
    for (int i = 0; i < 20; i++) idle("partial_init");
    for (int i = 0; i < PAGES; i++) model_mem[i] = '0;
    do_reset(1'b1);
    run_init(1'b0);
    tick("rd_p7_cleared", 1'b1, 7, 1'b0, 0, 3'd0, 3'd0, 1'b0);
    tick("rd_p42_cleared", 1'b1, 42, 1'b0, 0, 3'd0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memshare_l1pa_spr_regfile.md
MEMSHARE_L1PA_SPR_REGFILE -- requirements
Module: memshare_l1pa_spr_regfile

Parameters
REQ-001 RQST_BITWIDTH, default 5, width of request flags driven by the address mapping unit.
REQ-002 REGFILE_PAGE_NUM, default 43, number of L1PA_SPR pages held.
REQ-003 REGFILE_ADDR_WIDTH, default RQST_BITWIDTH, read/write address width.
REQ-004 L1PA_SHIFT_BITWIDTH, default $clog2(RQST_BITWIDTH), width of shift and shiftDelta fields.

Interface
REQ-005 sys_clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 rd_en_i  in  1  read request qualifier.
REQ-008 regFile_raddr_i  in  REGFILE_ADDR_WIDTH  read page address from the mapping unit.
REQ-009 wr_en_i  in  1  page write request.
REQ-010 waddr_i  in  REGFILE_ADDR_WIDTH  write page address.
REQ-011 wdata_shift_i, wdata_shiftDelta_i  in  L1PA_SHIFT_BITWIDTH each  page fields to store.
REQ-012 wdata_isGtr_i  in  1  page isGreaterThan-0 flag.
REQ-013 l1pa_shift_o, shiftDelta_o  out  L1PA_SHIFT_BITWIDTH each  feedback fields to the mapping unit.
REQ-014 isGtr_o  out  1  feedback LSB of L1PA_SPR.
REQ-015 rdata_valid_o  out  1  read data valid strobe.
REQ-016 init_done_o  out  1  high once page clearing completes.
REQ-017 raddr_err_o, wr_err_o  out  1 each  one-cycle error pulses.

Function
REQ-018 Page word = {shift, shiftDelta, isGtr}, 2*L1PA_SHIFT_BITWIDTH+1 bits, REGFILE_PAGE_NUM entries.
REQ-019 FSM states INIT, READY; rst forces INIT with clear counter = 0.
REQ-020 INIT: writes zero to page[counter] each cycle, counter increments; at counter == REGFILE_PAGE_NUM-1 go to READY next cycle; clear takes exactly REGFILE_PAGE_NUM cycles.
REQ-021 init_done_o = 1 only in READY.
REQ-022 In INIT, wr_en_i ignored and wr_err_o pulses; rd_en_i returns zero fields with rdata_valid_o = 1 one cycle later.
REQ-023 Read latency exactly 1 cycle: rd_en_i at cycle N -> fields and rdata_valid_o = 1 at N+1; rdata_valid_o = 0 when no read at N.
REQ-024 Output fields hold last read value while rdata_valid_o = 0.
REQ-025 regFile_raddr_i >= REGFILE_PAGE_NUM with rd_en_i: fields = 0, rdata_valid_o = 1, raddr_err_o = 1 at N+1.
REQ-026 wr_en_i in READY with waddr_i < REGFILE_PAGE_NUM: page updated at clock edge; waddr_i out of range: no update, wr_err_o = 1 next cycle.
REQ-027 Same-cycle read and write to same valid address: read returns new write data (write-through bypass).
REQ-028 Multiple requests are never queued; one read and one write accepted per cycle.

Reset
REQ-029 On rst: all outputs 0, rdata_valid_o = 0, init_done_o = 0, error pulses 0, FSM to INIT.
REQ-030 rst asserted mid-INIT or mid-READY restarts the full clear sequence; pending read dropped (no valid next cycle).
REQ-031 Page contents undefined only until INIT completes; reads during INIT return 0 regardless.

Verification
REQ-032 Release rst -> init_done_o rises exactly 43 cycles later; reading pages 0..42 all return 0.
REQ-033 Write page 7 {shift=3, delta=2, isGtr=1}, then rd_en_i addr 7 -> next cycle outputs 3, 2, 1, rdata_valid_o = 1.
REQ-034 Same cycle write page 12 {1,4,0} and read page 12 -> next cycle outputs 1, 4, 0.
REQ-035 Read addr 50 -> outputs 0, raddr_err_o = 1 for one cycle; write addr 45 -> wr_err_o = 1, no page changed.
REQ-036 Write during INIT -> wr_err_o = 1, page stays 0 after init; rst at INIT cycle 20 -> init_done_o rises 43 cycles after rst release.
REQ-037 Back-to-back reads pages 1,2,3 -> three consecutive valid cycles, data in order, no bubbles.
